// File: rtl/ysyx_23060020_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_23060020_pkg;

  // Fetch FSM states: waiting for a request, address phase, data phase,
  // presenting the result to the core.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } ifu_state_t;

  // addi x0,x0,0 -- driven on instw whenever no instruction is presented
  localparam logic [31:0] NOP_INST = 32'h00000013;

  // AXI-lite OKAY response code
  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_23060020_ifu_buf.sv
// One-entry last-fetch buffer: remembers the most recent successful fetch so
// that a repeated fetch of the same pc can be answered without the bus.
module ysyx_23060020_ifu_buf #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          DATA_W   = 32,
  parameter logic [DATA_W-1:0]    NOP_INST = ysyx_23060020_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_pc,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval
);

  logic              valid_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] data_reg;

  // Invalidate wins over fill; the FSM never requests both in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      data_reg  <= NOP_INST;
    end else if (inval) begin
      valid_reg <= 1'b0;
    end else if (fill) begin
      valid_reg <= 1'b1;
      pc_reg    <= fill_pc;
      data_reg  <= fill_data;
    end
  end

  assign hit      = valid_reg && (lookup_pc == pc_reg);
  assign hit_data = data_reg;

endmodule

// File: rtl/ysyx_23060020_ifu.sv
// Instruction fetch unit: answers core fetch requests from a one-entry
// buffer or via a single-beat AR/R read, and hands the word back with a
// valid/ready handshake. Every output is a register.
module ysyx_23060020_ifu
  import ysyx_23060020_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_INST = ysyx_23060020_pkg::NOP_INST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              fetch_req,
  input  logic              inst_ready,
  input  logic              flush,
  output logic [DATA_W-1:0] instw,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] mem_araddr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rvalid,
  output logic              mem_rready
);

  ifu_state_t        state_reg, state_next;
  logic              drop_reg, drop_next;
  logic [DATA_W-1:0] instw_reg, instw_next;
  logic              valid_reg, valid_next;
  logic              err_reg, err_next;
  logic [ADDR_W-1:0] araddr_reg, araddr_next;
  logic              arvalid_reg, arvalid_next;
  logic              rready_reg, rready_next;

  logic              buf_hit;
  logic [DATA_W-1:0] buf_data;
  logic              buf_fill;
  logic              buf_inval;

  // mem_araddr doubles as the captured request pc: it is written only in
  // IDLE and stays put until the next miss, so it names the fill address.
  ysyx_23060020_ifu_buf #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NOP_INST (NOP_INST)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc),
    .hit       (buf_hit),
    .hit_data  (buf_data),
    .fill      (buf_fill),
    .fill_pc   (araddr_reg),
    .fill_data (mem_rdata),
    .inval     (buf_inval)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      drop_reg    <= 1'b0;
      instw_reg   <= NOP_INST;
      valid_reg   <= 1'b0;
      err_reg     <= 1'b0;
      araddr_reg  <= '0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      drop_reg    <= drop_next;
      instw_reg   <= instw_next;
      valid_reg   <= valid_next;
      err_reg     <= err_next;
      araddr_reg  <= araddr_next;
      arvalid_reg <= arvalid_next;
      rready_reg  <= rready_next;
    end
  end

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    state_next   = state_reg;
    drop_next    = drop_reg;
    instw_next   = instw_reg;
    valid_next   = valid_reg;
    err_next     = err_reg;
    araddr_next  = araddr_reg;
    arvalid_next = arvalid_reg;
    rready_next  = rready_reg;
    buf_fill     = 1'b0;
    buf_inval    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (flush) begin
          buf_inval = 1'b1;
        end else if (fetch_req) begin
          if (pc[1:0] != 2'b00) begin
            instw_next = NOP_INST;
            err_next   = 1'b1;
            valid_next = 1'b1;
            state_next = RESP;
          end else if (buf_hit) begin
            instw_next = buf_data;
            err_next   = 1'b0;
            valid_next = 1'b1;
            state_next = RESP;
          end else begin
            araddr_next  = pc;
            arvalid_next = 1'b1;
            state_next   = ADDR;
          end
        end
      end

      ADDR: begin
        // A flush only marks the response for discard; the address stays
        // offered until the slave takes it.
        if (flush) begin
          buf_inval = 1'b1;
          drop_next = 1'b1;
        end
        if (mem_arready) begin
          arvalid_next = 1'b0;
          rready_next  = 1'b1;
          state_next   = DATA;
        end
      end

      DATA: begin
        if (flush) begin
          buf_inval = 1'b1;
          drop_next = 1'b1;
        end
        if (mem_rvalid && rready_reg) begin
          rready_next = 1'b0;
          if (drop_reg || flush) begin
            drop_next  = 1'b0;
            state_next = IDLE;
          end else begin
            valid_next = 1'b1;
            state_next = RESP;
            if (mem_rresp == RESP_OKAY) begin
              buf_fill   = 1'b1;
              instw_next = mem_rdata;
              err_next   = 1'b0;
            end else begin
              instw_next = NOP_INST;
              err_next   = 1'b1;
            end
          end
        end
      end

      RESP: begin
        // flush takes priority over a simultaneous consume
        if (flush || inst_ready) begin
          buf_inval  = flush;
          valid_next = 1'b0;
          instw_next = NOP_INST;
          err_next   = 1'b0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign instw       = instw_reg;
  assign inst_valid  = valid_reg;
  assign fetch_err   = err_reg;
  assign mem_araddr  = araddr_reg;
  assign mem_arvalid = arvalid_reg;
  assign mem_rready  = rready_reg;

endmodule

// File: tb/tb_ysyx_23060020_ifu.sv
// Bench for the fetch unit: bench-side memory responder, transaction-level
// reference model and a per-cycle output checker.
module tb_ysyx_23060020_ifu;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fetch_req, inst_ready, flush;
  logic [31:0] instw;
  logic        inst_valid, fetch_err;
  logic [31:0] mem_araddr;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid, mem_rready;

  ysyx_23060020_ifu dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_req   (fetch_req),
    .inst_ready  (inst_ready),
    .flush       (flush),
    .instw       (instw),
    .inst_valid  (inst_valid),
    .fetch_err   (fetch_err),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    chk(name, {31'b0, got}, {31'b0, want});
  endtask

  // ---------------- memory contents and responder knobs ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h80000000) return 32'h00500093;
    if (a == 32'h80000100) return 32'hDEADBEEF;
    return {a[15:0], a[31:16]} ^ 32'h13579BDF;
  endfunction

  int          ar_delay = 0;
  int          r_delay = 0;
  logic [1:0]  next_rresp = 2'b00;

  // Memory responder: arready after ar_delay cycles of arvalid, rvalid
  // r_delay cycles after the address handshake.
  initial begin
    logic        ar_fire, r_fire, pending;
    int          ar_cnt, r_cnt;
    logic [31:0] raddr;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rresp = '0;
    pending = 1'b0; ar_cnt = 0; r_cnt = 0; raddr = '0;
    forever begin
      @(negedge clk);
      ar_fire = mem_arvalid && mem_arready;
      r_fire  = mem_rvalid && mem_rready;
      @(posedge clk); #1;
      if (rst) begin
        mem_arready = 1'b0; mem_rvalid = 1'b0; pending = 1'b0; ar_cnt = 0;
      end else begin
        if (r_fire) begin
          mem_rvalid = 1'b0;
          mem_rdata  = $urandom;
          mem_rresp  = 2'($urandom_range(0, 3));
        end
        if (ar_fire) begin
          mem_arready = 1'b0;
          pending     = 1'b1;
          raddr       = mem_araddr;
          r_cnt       = r_delay;
          ar_cnt      = 0;
        end else if (mem_arvalid && !mem_arready) begin
          if (ar_cnt >= ar_delay) begin
            mem_arready = 1'b1;
            ar_cnt      = 0;
          end else begin
            ar_cnt++;
          end
        end
        if (pending) begin
          if (r_cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_word(raddr);
            mem_rresp  = next_rresp;
            pending    = 1'b0;
          end else begin
            r_cnt--;
          end
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  logic        cv = 1'b0;
  logic [31:0] cpc = '0;
  logic [31:0] cdat = '0;

  // Expectations shared with the per-cycle checker.
  logic        exp_active = 1'b0;
  logic [31:0] exp_data = NOP;
  logic        exp_err = 1'b0;
  logic        exp_bus = 1'b0;
  logic [31:0] exp_addr = '0;
  logic        saw_ar = 1'b0;

  logic [31:0] got_instw;
  logic        got_err;

  // Per-cycle checker on the falling edge.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr  = '0;
    forever begin
      @(negedge clk);
      if (inst_valid) begin
        chk1("resp_expected", exp_active, 1'b1);
        chk("instw", instw, exp_data);
        chk1("fetch_err", fetch_err, exp_err);
      end else begin
        chk("instw_idle", instw, NOP);
      end
      if (mem_arvalid) begin
        saw_ar = 1'b1;
        chk1("ar_expected", exp_bus, 1'b1);
        chk("araddr", mem_araddr, exp_addr);
      end
      if (prev_stall && !rst) begin
        chk1("ar_hold", mem_arvalid, 1'b1);
        chk("ar_hold_addr", mem_araddr, prev_addr);
      end
      prev_stall = mem_arvalid && !mem_arready && !rst;
      prev_addr  = mem_araddr;
    end
  end

  function automatic bit is_miss(input logic [31:0] a);
    return (a[1:0] == 2'b00) && !(cv && cpc == a);
  endfunction

  // Full fetch: request, wait for the result, hold it, then consume or flush.
  task automatic fetch(input logic [31:0] a, input int ard, input int rd, input logic [1:0] rr,
                       input int hold, input bit flush_resp, output int lat);
    bit          bus;
    logic [31:0] d;
    bit          e;
    int          want_lat;
    if (a[1:0] != 2'b00) begin
      bus = 0; d = NOP; e = 1;
    end else if (cv && cpc == a) begin
      bus = 0; d = cdat; e = 0;
    end else begin
      bus = 1;
      if (rr == 2'b00) begin d = mem_word(a); e = 0; end
      else begin d = NOP; e = 1; end
    end
    want_lat = bus ? 3 + ard + rd : 1;
    ar_delay = ard; r_delay = rd; next_rresp = rr;
    exp_active = 1'b1; exp_data = d; exp_err = e; exp_bus = bus; exp_addr = a; saw_ar = 1'b0;
    pc = a; fetch_req = 1'b1;
    lat = 0;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(posedge clk); #1;
      fetch_req = 1'b0;
      pc = $urandom;
      if (inst_valid) begin lat = cyc; break; end
    end
    chk("latency", lat, want_lat);
    chk1("bus_used", saw_ar, bus);
    got_instw = instw;
    got_err   = fetch_err;
    repeat (hold) begin @(posedge clk); #1; end
    if (flush_resp) begin
      flush = 1'b1; inst_ready = 1'($urandom_range(0, 1));
    end else begin
      inst_ready = 1'b1;
    end
    @(posedge clk); #1;
    flush = 1'b0; inst_ready = 1'b0;
    exp_active = 1'b0; exp_bus = 1'b0;
    chk1("valid_drop", inst_valid, 1'b0);
    if (bus && rr == 2'b00) begin cv = 1'b1; cpc = a; cdat = mem_word(a); end
    if (flush_resp) cv = 1'b0;
    $display("fetch pc=%h ar=%0d r=%0d rresp=%0d hold=%0d flush=%0d -> lat=%0d instw=%h err=%0b",
             a, ard, rd, rr, hold, flush_resp, lat, got_instw, got_err);
  endtask

  // Miss with a flush during ADDR/DATA (flush cycle fc, 1-based after request).
  task automatic fetch_drop(input logic [31:0] a, input int ard, input int rd, input int fc);
    ar_delay = ard; r_delay = rd; next_rresp = 2'($urandom_range(0, 3));
    exp_active = 1'b0; exp_bus = 1'b1; exp_addr = a; saw_ar = 1'b0;
    pc = a; fetch_req = 1'b1;
    for (int cyc = 1; cyc <= 4 + ard + rd; cyc++) begin
      @(posedge clk); #1;
      fetch_req = 1'b0;
      pc = $urandom;
      flush = (cyc == fc);
    end
    flush = 1'b0;
    chk1("drop_bus_used", saw_ar, 1'b1);
    chk1("drop_no_valid", inst_valid, 1'b0);
    chk1("drop_no_rvalid", mem_rvalid, 1'b0);
    cv = 1'b0; exp_bus = 1'b0;
    $display("drop  pc=%h ar=%0d r=%0d flush_cycle=%0d -> inst_valid=%0b", a, ard, rd, fc, inst_valid);
  endtask

  // Flush in IDLE together with a request: the request is ignored.
  task automatic idle_flush(input logic [31:0] a);
    exp_active = 1'b0; exp_bus = 1'b0; saw_ar = 1'b0;
    pc = a; fetch_req = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    fetch_req = 1'b0; flush = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk1("iflush_no_valid", inst_valid, 1'b0);
    chk1("iflush_no_bus", saw_ar, 1'b0);
    cv = 1'b0;
    $display("iflush pc=%h -> inst_valid=%0b", a, inst_valid);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instw"}, instw, NOP);
    chk1({tag, "_valid"}, inst_valid, 1'b0);
    chk1({tag, "_err"}, fetch_err, 1'b0);
    chk1({tag, "_arvalid"}, mem_arvalid, 1'b0);
    chk({tag, "_araddr"}, mem_araddr, 32'h0);
    chk1({tag, "_rready"}, mem_rready, 1'b0);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "timeout");
  end

  // ---------------- main stimulus ----------------
  initial begin
    int lat;
    logic [31:0] a;
    int op, ard, rd;
    rst = 1'b1; pc = '0; fetch_req = 1'b0; inst_ready = 1'b0; flush = 1'b0;
    #2;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // 1: zero-wait miss
    fetch(32'h80000000, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t1_lat", lat, 3);
    chk("t1_instw", got_instw, 32'h00500093);
    chk1("t1_err", got_err, 1'b0);
    // 2: hit
    fetch(32'h80000000, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t2_lat", lat, 1);
    chk("t2_instw", got_instw, 32'h00500093);
    // 3: slow address, bus error, then re-fetch misses
    fetch(32'h80000040, 3, 0, 2'b10, 0, 1'b0, lat);
    chk("t3_lat", lat, 6);
    chk("t3_instw", got_instw, 32'h00000013);
    chk1("t3_err", got_err, 1'b1);
    fetch(32'h80000040, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t3_refetch_lat", lat, 3);
    // 4: misaligned
    fetch(32'h80000002, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t4_lat", lat, 1);
    chk("t4_instw", got_instw, 32'h00000013);
    chk1("t4_err", got_err, 1'b1);
    // 5: flush during ADDR, then the same pc misses
    fetch_drop(32'h80000100, 3, 0, 2);
    fetch(32'h80000100, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t5_lat", lat, 3);
    chk("t5_instw", got_instw, 32'hDEADBEEF);
    // 6: hold result 4 cycles then flush; then reset mid-DATA
    fetch(32'h80000100, 0, 0, 2'b00, 4, 1'b1, lat);
    chk("t6_lat", lat, 1);
    exp_active = 1'b0; exp_bus = 1'b1; exp_addr = 32'h80000200; saw_ar = 1'b0;
    ar_delay = 0; r_delay = 3; next_rresp = 2'b00;
    pc = 32'h80000200; fetch_req = 1'b1;
    @(posedge clk); #1; fetch_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("t6_in_data", mem_rready, 1'b1);
    #2; rst = 1'b1; #1;
    chk_reset_vals("t6_async");
    exp_bus = 1'b0; exp_addr = '0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    cv = 1'b0;
    @(posedge clk); #1;
    $display("reset mid-DATA -> inst_valid=%0b arvalid=%0b rready=%0b", inst_valid, mem_arvalid, mem_rready);
    fetch(32'h80000100, 0, 0, 2'b00, 0, 1'b0, lat);
    chk("t6_post_reset_lat", lat, 3);

    // Randomized mix
    for (int i = 0; i < 160; i++) begin
      a = 32'h80000000 + (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
      op  = $urandom_range(0, 9);
      ard = $urandom_range(0, 3);
      rd  = $urandom_range(0, 3);
      if (op >= 7 && op <= 8 && is_miss(a)) begin
        fetch_drop(a, ard, rd, $urandom_range(1, 2 + ard + rd));
      end else if (op == 9) begin
        idle_flush(a);
      end else begin
        fetch(a, ard, rd, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0), lat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
